// File: rtl/ahb_burst_worker.sv
// AHB requester moving one pNUM_BEATS-word payload as a single fixed-length INCR burst.
// Optional AHB_BURST_WORKER_BYTE_SWAP_EN reverses bytes within each bus word (wdata and rdata).
//
// state | meaning
// IDLE  | waiting for I_go; job fields captured on acceptance
// ADDR  | NONSEQ address phase of beat 0
// BURST | SEQ address beat k overlapped with data phase of beat k-1
// LAST  | final data phase, bus driven IDLE
// ERR   | second cycle of a two-cycle ERROR response, bus IDLE
// DONE  | one-cycle completion pulse, then IDLE
module ahb_burst_worker #(
  parameter int unsigned pAHB_ADDR_WIDTH          = 32,
  parameter int unsigned pAHB_DATA_WIDTH          = 32,
  parameter int unsigned pNUM_BEATS               = 4,
  parameter logic [3:0]  pAHB_HPROT_VALUE         = 4'b0011,
  parameter bit          pAHB_HMASTLOCK_VALUE     = 1'b1,
  parameter bit          pAHB_HNONSEC_VALUE       = 1'b0,
  parameter int unsigned pMAX_TRANSFER_WAIT_COUNT = 16,
  parameter bit          pREVERSE_WORD_ORDER      = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic [pAHB_ADDR_WIDTH-1:0]             O_haddr,
  output logic [2:0]                             O_hburst,
  output logic [2:0]                             O_hsize,
  output logic [3:0]                             O_hprot,
  output logic                                   O_hnonsec,
  output logic                                   O_hmastlock,
  output logic [1:0]                             O_htrans,
  output logic                                   O_hwrite,
  output logic [pAHB_DATA_WIDTH-1:0]             O_hwdata,
  input  logic [pAHB_DATA_WIDTH-1:0]             I_hrdata,
  input  logic                                   I_hready,
  input  logic [1:0]                             I_hresp,
  input  logic [pAHB_ADDR_WIDTH-1:0]             I_int_addr,
  input  logic [pNUM_BEATS*pAHB_DATA_WIDTH-1:0]  I_int_wdata,
  input  logic                                   I_int_write,
  input  logic                                   I_go,
  output logic [pNUM_BEATS*pAHB_DATA_WIDTH-1:0]  O_int_rdata,
  output logic                                   O_int_rdata_valid,
  output logic                                   O_done,
  output logic                                   O_error,
  output logic                                   O_busy
);

  localparam int unsigned W       = pAHB_DATA_WIDTH;
  localparam int unsigned N       = pNUM_BEATS;
  localparam int unsigned PW      = N * W;
  localparam int unsigned BYTES   = W / 8;
  localparam int unsigned ALIGN_W = $clog2(N * BYTES);
  localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WAIT_W  = $clog2(pMAX_TRANSFER_WAIT_COUNT + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(pMAX_TRANSFER_WAIT_COUNT - 1);
  localparam logic [2:0] HSIZE  = (W == 128) ? 3'b100 : (W == 64) ? 3'b011 : 3'b010;
  localparam logic [2:0] HBURST = (N == 16) ? 3'b111 : (N == 8) ? 3'b101 :
                                  (N == 4)  ? 3'b011 : 3'b000;

  typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST, ERR, DONE} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             acnt_q, acnt_d;
  logic [CNT_W-1:0]             dcnt_q, dcnt_d;
  logic [WAIT_W-1:0]            wait_q, wait_d;
  logic                         err_q, err_d;
  logic [pAHB_ADDR_WIDTH-1:0]   base_q;
  logic [PW-1:0]                payload_q;
  logic                         write_q;
  logic [PW-1:0]                rdata_q;

  logic                         accept;
  logic                         capture;
  logic                         misaligned;
  logic                         bus_err;
  logic                         addr_phase;
  logic                         data_phase;
  logic [CNT_W-1:0]             widx;
  logic                         unused_hresp;

  function automatic logic [W-1:0] swap_bytes(input logic [W-1:0] d);
`ifdef AHB_BURST_WORKER_BYTE_SWAP_EN
    for (int i = 0; i < int'(BYTES); i++) begin
      swap_bytes[i*8 +: 8] = d[(int'(BYTES)-1-i)*8 +: 8];
    end
`else
    swap_bytes = d;
`endif
  endfunction

  assign misaligned   = (I_int_addr[ALIGN_W-1:0] != '0);
  assign bus_err      = I_hresp[0] & ~I_hready;
  assign unused_hresp = I_hresp[1];
  assign addr_phase   = (state_q == ADDR) || (state_q == BURST);
  assign data_phase   = (state_q == BURST) || (state_q == LAST);
  // Word slot touched by the current data phase; same mapping for write and read.
  assign widx         = pREVERSE_WORD_ORDER ? (LAST_IDX - dcnt_q) : dcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acnt_q    <= '0;
      dcnt_q    <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      base_q    <= '0;
      payload_q <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (accept) begin
        base_q    <= I_int_addr;
        payload_q <= I_int_wdata;
        write_q   <= I_int_write;
      end
      if (capture) begin
        rdata_q[widx*W +: W] <= swap_bytes(I_hrdata);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    wait_d  = wait_q;
    err_d   = err_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_go) begin
          accept  = 1'b1;
          acnt_d  = '0;
          dcnt_d  = '0;
          wait_d  = WAIT_LOAD;
          err_d   = misaligned;
          state_d = misaligned ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (I_hready) begin
          acnt_d  = acnt_q + 1'b1;
          wait_d  = WAIT_LOAD;
          state_d = (N == 1) ? LAST : BURST;
        end else if (wait_q == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      BURST, LAST: begin
        if (bus_err) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (I_hready) begin
          capture = ~write_q;
          wait_d  = WAIT_LOAD;
          if (state_q == LAST) begin
            state_d = DONE;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
            if (acnt_q == LAST_IDX) begin
              state_d = LAST;
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end else if (wait_q == '0) begin
          // Slave held HREADY low too long: abandon the burst.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ERR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    O_htrans = 2'b00;
    if (state_q == ADDR) begin
      O_htrans = 2'b10;
    end else if (state_q == BURST) begin
      O_htrans = 2'b11;
    end
  end

  assign O_haddr  = addr_phase
                  ? base_q + pAHB_ADDR_WIDTH'(acnt_q) * pAHB_ADDR_WIDTH'(BYTES)
                  : '0;
  assign O_hwrite = addr_phase & write_q;
  assign O_hwdata = (data_phase && write_q) ? swap_bytes(payload_q[widx*W +: W]) : '0;

  assign O_hburst    = HBURST;
  assign O_hsize     = HSIZE;
  assign O_hprot     = pAHB_HPROT_VALUE;
  assign O_hnonsec   = pAHB_HNONSEC_VALUE;
  assign O_hmastlock = (state_q != IDLE) ? pAHB_HMASTLOCK_VALUE : 1'b0;

  assign O_busy            = (state_q != IDLE);
  assign O_done            = (state_q == DONE);
  assign O_error           = O_done & err_q;
  assign O_int_rdata_valid = O_done & ~err_q & ~write_q;
  assign O_int_rdata       = rdata_q;

endmodule

// File: tb/tb_ahb_burst_worker.sv
// Scoreboard bench for ahb_burst_worker (default parameters: W=32, N=4, reversed word order).
// A small AHB slave model supplies HREADY/HRESP/HRDATA; a monitor checks bus beats and job completion.
module tb_ahb_burst_worker;
  localparam int AW = 32;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int PW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] O_haddr;
  logic [2:0]    O_hburst;
  logic [2:0]    O_hsize;
  logic [3:0]    O_hprot;
  logic          O_hnonsec;
  logic          O_hmastlock;
  logic [1:0]    O_htrans;
  logic          O_hwrite;
  logic [W-1:0]  O_hwdata;
  logic [W-1:0]  I_hrdata;
  logic          I_hready;
  logic [1:0]    I_hresp;
  logic [AW-1:0] I_int_addr;
  logic [PW-1:0] I_int_wdata;
  logic          I_int_write;
  logic          I_go;
  logic [PW-1:0] O_int_rdata;
  logic          O_int_rdata_valid;
  logic          O_done;
  logic          O_error;
  logic          O_busy;

  always #5 clk = ~clk;

  ahb_burst_worker dut (
    .clk(clk), .rst_n(rst_n),
    .O_haddr(O_haddr), .O_hburst(O_hburst), .O_hsize(O_hsize), .O_hprot(O_hprot),
    .O_hnonsec(O_hnonsec), .O_hmastlock(O_hmastlock), .O_htrans(O_htrans),
    .O_hwrite(O_hwrite), .O_hwdata(O_hwdata), .I_hrdata(I_hrdata),
    .I_hready(I_hready), .I_hresp(I_hresp), .I_int_addr(I_int_addr),
    .I_int_wdata(I_int_wdata), .I_int_write(I_int_write), .I_go(I_go),
    .O_int_rdata(O_int_rdata), .O_int_rdata_valid(O_int_rdata_valid),
    .O_done(O_done), .O_error(O_error), .O_busy(O_busy)
  );

  typedef struct packed {
    logic [31:0]   go_edge;
    logic [31:0]   lat;
    logic          err;
    logic          valid;
    logic          chk_rd;
    logic [PW-1:0] rdata;
  } done_exp_t;

  done_exp_t     done_q[$];
  logic [AW-1:0] addr_q[$];
  logic [1:0]    trans_q[$];
  logic [W-1:0]  wd_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        cur_write = 1'b0;

  int           stall_beat = -1;
  int           stall_len  = 0;
  int           err_beat   = -1;
  logic [W-1:0] rd_words [N];
  logic         dp_active  = 1'b0;
  int           dp_beat    = 0;
  int           dp_wait    = 0;
  int           next_beat  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: a data phase opens after an accepted address phase and closes on HREADY high.
  initial begin
    logic dp_done, acc, nonseq, clr;
    I_hready = 1'b1;
    I_hresp  = 2'b00;
    I_hrdata = '0;
    forever begin
      @(negedge clk);
      dp_done = dp_active && I_hready;
      acc     = O_htrans[1] && I_hready;
      nonseq  = (O_htrans == 2'b10);
      clr     = !rst_n || O_done;
      @(posedge clk);
      #1;
      if (clr) begin
        dp_active = 1'b0;
      end else begin
        if (dp_done) dp_active = 1'b0;
        else if (dp_active) dp_wait++;
        if (acc) begin
          if (nonseq) next_beat = 0;
          dp_active = 1'b1;
          dp_beat   = next_beat;
          dp_wait   = 0;
          next_beat++;
        end
      end
      I_hready = 1'b1;
      I_hresp  = 2'b00;
      I_hrdata = '0;
      if (dp_active) begin
        I_hrdata = rd_words[dp_beat];
        if (dp_beat == err_beat) begin
          I_hresp  = 2'b01;
          I_hready = (dp_wait >= 1);
        end else if (dp_beat == stall_beat && dp_wait < stall_len) begin
          I_hready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or a completion.
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [1:0]    prev_trans;
    logic [W-1:0]  prev_wdata;
    done_exp_t     e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_trans = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && O_htrans[1]) begin
        chk("hold_haddr", O_haddr, prev_addr);
        chk("hold_htrans", O_htrans, prev_trans);
        chk("hold_hwdata", O_hwdata, prev_wdata);
      end
      if (O_htrans[1] && I_hready) begin
        chk("addr_beat_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          chk("haddr", O_haddr, addr_q.pop_front());
          chk("htrans", O_htrans, trans_q.pop_front());
          chk("hwrite", O_hwrite, cur_write);
          chk("hmastlock", O_hmastlock, 1'b1);
        end
      end
      if (cur_write && dp_active && I_hready) begin
        chk("wdata_beat_expected", wd_q.size() != 0, 1);
        if (wd_q.size() != 0) chk("hwdata", O_hwdata, wd_q.pop_front());
      end
      if (O_done) begin
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          chk("done_latency", cyc - e.go_edge + 1, e.lat);
          chk("done_error", O_error, e.err);
          chk("rdata_valid", O_int_rdata_valid, e.valid);
          if (e.chk_rd) chk("int_rdata", O_int_rdata, e.rdata);
        end
      end
      prev_stall = O_htrans[1] && !I_hready;
      prev_addr  = O_haddr;
      prev_trans = O_htrans;
      prev_wdata = O_hwdata;
    end
  end

  // Called just after a rising edge; I_go is sampled on the next edge ("edge 0").
  task automatic start_job(input logic [AW-1:0] addr, input logic wr, input logic [PW-1:0] payload,
                           input int n_addr, input int n_wd, input int lat, input logic err,
                           input logic valid, input logic chk_rd, input logic [PW-1:0] rdata);
    done_exp_t e;
    cur_write = wr;
    for (int k = 0; k < n_addr; k++) begin
      addr_q.push_back(addr + AW'(k * 4));
      trans_q.push_back((k == 0) ? 2'b10 : 2'b11);
    end
    for (int k = 0; k < n_wd; k++) wd_q.push_back(payload[(N-1-k)*W +: W]);
    if (lat > 0) begin
      e.go_edge = cyc + 1;
      e.lat     = lat;
      e.err     = err;
      e.valid   = valid;
      e.chk_rd  = chk_rd;
      e.rdata   = rdata;
      done_q.push_back(e);
    end
    I_int_addr  = addr;
    I_int_wdata = payload;
    I_int_write = wr;
    I_go        = 1'b1;
    @(posedge clk);
    #1;
    I_go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_completed"}, done_q.size() == 0, 1);
    chk({name, "_addr_beats_left"}, addr_q.size(), 0);
    chk({name, "_wdata_beats_left"}, wd_q.size(), 0);
    done_q.delete();
    addr_q.delete();
    trans_q.delete();
    wd_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_haddr"}, O_haddr, 0);
    chk({name, "_htrans"}, O_htrans, 0);
    chk({name, "_hwrite"}, O_hwrite, 0);
    chk({name, "_hwdata"}, O_hwdata, 0);
    chk({name, "_hmastlock"}, O_hmastlock, 0);
    chk({name, "_int_rdata"}, O_int_rdata, 0);
    chk({name, "_rdata_valid"}, O_int_rdata_valid, 0);
    chk({name, "_done"}, O_done, 0);
    chk({name, "_error"}, O_error, 0);
    chk({name, "_busy"}, O_busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    I_go        = 1'b0;
    I_int_addr  = '0;
    I_int_wdata = '0;
    I_int_write = 1'b0;
    for (int k = 0; k < N; k++) rd_words[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("hburst_incr4", O_hburst, 3'b011);
    chk("hsize_word", O_hsize, 3'b010);
    chk("hprot", O_hprot, 4'b0011);
    chk("hnonsec", O_hnonsec, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 4 beats, most significant word first.
    wd_q.push_back(32'h31c30019);
    wd_q.push_back(32'h67d4acf1);
    wd_q.push_back(32'hbcb25768);
    wd_q.push_back(32'h708627ae);
    start_job(32'h40, 1'b1, 128'h31c3001967d4acf1bcb25768708627ae, 4, 0, 6, 1'b0, 1'b0, 1'b0, '0);
    wait_done("write4");

    // Read 4 beats; beat 0 lands in the top word.
    rd_words[0] = 32'hA0; rd_words[1] = 32'hA1; rd_words[2] = 32'hA2; rd_words[3] = 32'hA3;
    start_job(32'h80, 1'b0, '0, 4, 0, 6, 1'b0, 1'b1, 1'b1,
              128'h000000A0000000A1000000A2000000A3);
    wait_done("read4");

    // Three wait states on beat 2.
    stall_beat = 2; stall_len = 3;
    start_job(32'h100, 1'b1, 128'h0123456789abcdeffedcba9876543210, 4, 4, 9,
              1'b0, 1'b0, 1'b0, '0);
    wait_done("write_stall");
    stall_beat = -1; stall_len = 0;

    // ERROR response on beat 1 of a read.
    err_beat = 1;
    rd_words[0] = 32'hB0; rd_words[1] = 32'hB1; rd_words[2] = 32'hB2; rd_words[3] = 32'hB3;
    start_job(32'hC0, 1'b0, '0, 2, 0, 5, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_htrans_idle", O_htrans, 2'b00);
    chk("err_busy", O_busy, 1'b1);
    wait_done("read_error");
    err_beat = -1;

    // HREADY stuck low on beat 1: timeout after 16 wait cycles.
    stall_beat = 1; stall_len = 100;
    start_job(32'h200, 1'b1, 128'hdeadbeefcafef00d1122334455667788, 2, 1, 19,
              1'b1, 1'b0, 1'b0, '0);
    wait_done("timeout");
    stall_beat = -1; stall_len = 0;

    // Misaligned start address: immediate error, no bus traffic.
    start_job(32'h44, 1'b1, 128'h0, 0, 0, 1, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("misalign_htrans", O_htrans, 2'b00);
    chk("misalign_done", O_done, 1'b1);
    wait_done("misaligned");

    // Reset asserted during the beat-2 data phase.
    start_job(32'h300, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 4, 3, 0,
              1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done("reset_abort");

    // Normal read after the reset.
    rd_words[0] = 32'h11111111; rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333; rd_words[3] = 32'h44444444;
    start_job(32'h340, 1'b0, '0, 4, 0, 6, 1'b0, 1'b1, 1'b1,
              128'h11111111222222223333333344444444);
    wait_done("read_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
